// File: rtl/wb_loopback_responder.sv
// wb_loopback_responder: Wishbone classic-cycle responder with a byte-wide loopback FIFO register map
//
// Ports:
//   clk_i, rst_n_i          clock (rising edge) and asynchronous active-low reset
//   cyc_i, stb_i, we_i      Wishbone cycle, strobe and write enable
//   adr_i [ADDR_WIDTH]      register address (0 CTRL, 1 DATA, 2 STAT, 3 IRQ)
//   dat_i [DATA_WIDTH]      write data
//   dat_o [DATA_WIDTH]      read data, non-zero only alongside ack_o
//   ack_o                   one-cycle transfer acknowledge
//   err_o                   error termination, present only when WB_RESP_ERR_EN is defined
//   irq_o                   registered level interrupt
//
// Build option: define WB_RESP_ERR_EN to terminate overflowing writes and
// underflowing reads with err_o instead of ack_o.
module wb_loopback_responder #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 2,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  cyc_i,
    input  logic                  stb_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] adr_i,
    input  logic [DATA_WIDTH-1:0] dat_i,
    output logic [DATA_WIDTH-1:0] dat_o,
    output logic                  ack_o,
`ifdef WB_RESP_ERR_EN
    output logic                  err_o,
`endif
    output logic                  irq_o
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

    state_t                state_q;
    logic [3:0]            cnt_q;
    logic [ADDR_WIDTH-1:0] adr_q;
    logic                  we_q;
    logic [DATA_WIDTH-1:0] wdat_q;
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]         wp_q, rp_q;
    logic [CW-1:0]         count_q;
    logic                  ovf_q, unf_q;
    logic                  en_q, ie_q;
    logic [3:0]            wait_q;
    logic                  ack_q, irq_q;
    logic [DATA_WIDTH-1:0] dat_q;
`ifdef WB_RESP_ERR_EN
    logic                  err_q;
`endif

    logic                  empty_d, full_d, acc_d, data_d;
    logic                  push_d, pop_d, ovf_set_d, unf_set_d;
    logic                  stat_wr_d, ctrl_wr_d, done_d;
    logic [DATA_WIDTH-1:0] stat_d, ctrl_d, rdata_d;

    always_comb begin
        empty_d   = count_q == '0;
        full_d    = count_q == CW'(FIFO_DEPTH);
        acc_d     = state_q == S_ACK;
        // DATA accesses only have an effect while EN is set
        data_d    = acc_d && adr_q == ADDR_WIDTH'(1) && en_q;
        push_d    = data_d && we_q && !full_d;
        pop_d     = data_d && !we_q && !empty_d;
        ovf_set_d = data_d && we_q && full_d;
        unf_set_d = data_d && !we_q && empty_d;
        stat_wr_d = acc_d && we_q && adr_q == ADDR_WIDTH'(2);
        ctrl_wr_d = acc_d && we_q && adr_q == ADDR_WIDTH'(0);
        stat_d    = DATA_WIDTH'({empty_d, full_d, ovf_q, unf_q, 4'(count_q)});
        ctrl_d    = DATA_WIDTH'({en_q, ie_q, 2'b00, wait_q});
        rdata_d   = adr_q == ADDR_WIDTH'(0) ? ctrl_d :
                    adr_q == ADDR_WIDTH'(1) ? (pop_d ? mem[rp_q] : '0) :
                    adr_q == ADDR_WIDTH'(2) ? stat_d :
                    adr_q == ADDR_WIDTH'(3) ? DATA_WIDTH'(irq_q) : '0;
        // a termination still on the bus keeps IDLE from restarting the same access
`ifdef WB_RESP_ERR_EN
        done_d    = ack_q || err_q;
`else
        done_d    = ack_q;
`endif
    end

    always_ff @(posedge clk_i) begin
        if (push_d) mem[wp_q] <= wdat_q;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            adr_q   <= '0;
            we_q    <= 1'b0;
            wdat_q  <= '0;
            wp_q    <= '0;
            rp_q    <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            en_q    <= 1'b0;
            ie_q    <= 1'b0;
            wait_q  <= '0;
            ack_q   <= 1'b0;
            irq_q   <= 1'b0;
            dat_q   <= '0;
`ifdef WB_RESP_ERR_EN
            err_q   <= 1'b0;
`endif
        end else begin
            ack_q   <= 1'b0;
            dat_q   <= '0;
`ifdef WB_RESP_ERR_EN
            err_q   <= 1'b0;
`endif
            irq_q   <= ie_q && en_q && (!empty_d || ovf_q || unf_q);
            wp_q    <= wp_q + PW'(push_d);
            rp_q    <= rp_q + PW'(pop_d);
            count_q <= count_q + CW'(push_d) - CW'(pop_d);
            // a new set outranks a simultaneous write-1-to-clear
            ovf_q   <= ovf_set_d || (ovf_q && !(stat_wr_d && wdat_q[5]));
            unf_q   <= unf_set_d || (unf_q && !(stat_wr_d && wdat_q[4]));
            if (ctrl_wr_d) begin
                en_q   <= wdat_q[7];
                ie_q   <= wdat_q[6];
                wait_q <= wdat_q[3:0];
            end
            case (state_q)
                S_IDLE: begin
                    if (cyc_i && stb_i && !done_d) begin
                        adr_q   <= adr_i;
                        we_q    <= we_i;
                        wdat_q  <= dat_i;
                        cnt_q   <= wait_q;
                        state_q <= wait_q == 4'd0 ? S_ACK : S_WAIT;
                    end
                end
                S_WAIT: begin
                    cnt_q   <= cnt_q - 4'd1;
                    state_q <= !(cyc_i && stb_i) ? S_IDLE : cnt_q == 4'd1 ? S_ACK : S_WAIT;
                end
                S_ACK: begin
                    state_q <= S_IDLE;
                    dat_q   <= we_q ? '0 : rdata_d;
`ifdef WB_RESP_ERR_EN
                    err_q   <= ovf_set_d || unf_set_d;
                    ack_q   <= !(ovf_set_d || unf_set_d);
`else
                    ack_q   <= 1'b1;
`endif
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign dat_o = dat_q;
    assign ack_o = ack_q;
    assign irq_o = irq_q;
`ifdef WB_RESP_ERR_EN
    assign err_o = err_q;
`endif

endmodule

// File: tb/tb_wb_loopback_responder.sv
// tb_wb_loopback_responder: randomized self-checking bench for wb_loopback_responder against a queue-based register model
module tb_wb_loopback_responder;
    localparam int DEPTH = 8;
`ifdef WB_RESP_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [1:0] adr = '0;
    logic [7:0] wdat = '0;
    logic [7:0] dat_o;
    logic       ack_o, irq_o, err_w;

    always #5 clk = ~clk;

    wb_loopback_responder #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .FIFO_DEPTH(DEPTH)) dut (
        .clk_i(clk),
        .rst_n_i(rst_n),
        .cyc_i(cyc),
        .stb_i(stb),
        .we_i(we),
        .adr_i(adr),
        .dat_i(wdat),
        .dat_o(dat_o),
        .ack_o(ack_o),
`ifdef WB_RESP_ERR_EN
        .err_o(err_w),
`endif
        .irq_o(irq_o)
    );
`ifndef WB_RESP_ERR_EN
    assign err_w = 1'b0;
`endif

    int total = 0, bad = 0;

    byte unsigned q[$];
    bit           m_en, m_ie, m_ovf, m_unf;
    bit [3:0]     m_wt;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic bit m_irq();
        return m_ie && m_en && (q.size() != 0 || m_ovf || m_unf);
    endfunction

    task automatic m_reset();
        q.delete();
        m_en = 0; m_ie = 0; m_ovf = 0; m_unf = 0; m_wt = 0;
    endtask

    task automatic model(input bit w, input bit [1:0] a, input bit [7:0] d,
                         output bit [7:0] rd, output bit er);
        rd = 8'h00;
        er = 1'b0;
        case (a)
            2'd0: begin
                rd = {m_en, m_ie, 2'b00, m_wt};
                if (w) begin m_en = d[7]; m_ie = d[6]; m_wt = d[3:0]; end
            end
            2'd1: if (m_en) begin
                if (w) begin
                    if (q.size() == DEPTH) begin m_ovf = 1; er = ERR_EN; end
                    else q.push_back(d);
                end else begin
                    if (q.size() == 0) begin m_unf = 1; er = ERR_EN; end
                    else rd = q.pop_front();
                end
            end
            2'd2: begin
                rd = {q.size() == 0, q.size() == DEPTH, m_ovf, m_unf, 4'(q.size())};
                if (w) begin
                    if (d[5]) m_ovf = 0;
                    if (d[4]) m_unf = 0;
                end
            end
            default: rd = {7'b0, m_irq()};
        endcase
    endtask

    task automatic wb(input bit w, input bit [1:0] a, input bit [7:0] d, output logic [7:0] got);
        bit [7:0] erd;
        bit       eerr;
        int       k, lat_exp;
        logic     seen, sa, se;
        lat_exp = int'(m_wt) + 1;
        model(w, a, d, erd, eerr);
        cyc = 1; stb = 1; we = w; adr = a; wdat = d;
        seen = 0; sa = 0; se = 0; got = '0; k = 0;
        while (!seen && k < 40) begin
            @(posedge clk); #1; k++;
            if (ack_o || err_w) begin seen = 1; sa = ack_o; se = err_w; got = dat_o; end
        end
        cyc = 0; stb = 0;
        if (!seen) chk("timeout", 0, 1);
        else begin
            chk("latency", k - 1, lat_exp);
            chk("term", {sa, se}, {!eerr, eerr});
            if (!w && !eerr) chk($sformatf("rdata_a%0d", a), got, erd);
        end
        @(posedge clk); #1;
        chk("one_cycle", {ack_o, err_w}, 0);
        chk("irq", irq_o, m_irq());
    endtask

    logic [7:0] rd;
    logic [7:0] rst_exp [4] = '{8'h00, 8'h00, 8'h80, 8'h00};
    int         n;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        m_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack", ack_o, 0);
        chk("rst_dat", dat_o, 0);
        chk("rst_irq", irq_o, 0);
        rst_n = 1;
        @(posedge clk); #1;
        for (int a = 0; a < 4; a++) begin
            wb(0, 2'(a), 8'h00, rd);
            chk("reset_reg", rd, rst_exp[a]);
        end

        wb(1, 0, 8'h80, rd);
        wb(1, 1, 8'hA5, rd);
        wb(1, 1, 8'h5A, rd);
        wb(1, 1, 8'h3C, rd);
        wb(0, 2, 8'h00, rd); chk("stat3", rd, 8'h03);
        wb(0, 1, 8'h00, rd); chk("pop0", rd, 8'hA5);
        wb(0, 1, 8'h00, rd); chk("pop1", rd, 8'h5A);
        wb(0, 1, 8'h00, rd); chk("pop2", rd, 8'h3C);
        wb(0, 2, 8'h00, rd); chk("stat_empty", rd, 8'h80);

        wb(1, 0, 8'h85, rd);
        wb(0, 0, 8'h00, rd); chk("ctrl_wait5", rd, 8'h85);
        wb(1, 1, 8'h77, rd);
        cyc = 1; stb = 1; we = 0; adr = 2'd1;
        repeat (3) @(posedge clk);
        #1; cyc = 0; stb = 0;
        n = 0;
        repeat (10) begin @(posedge clk); #1; if (ack_o || err_w) n++; end
        chk("abort_noack", n, 0);
        wb(0, 2, 8'h00, rd); chk("abort_stat", rd, 8'h01);
        wb(1, 0, 8'h80, rd);
        wb(0, 1, 8'h00, rd);

        for (int i = 0; i < 9; i++) wb(1, 1, 8'(8'h10 + i), rd);
        wb(0, 2, 8'h00, rd); chk("stat_ovf", rd, 8'h68);
        wb(1, 2, 8'h20, rd);
        wb(0, 2, 8'h00, rd); chk("stat_w1c", rd, 8'h48);
        for (int i = 0; i < 8; i++) wb(0, 1, 8'h00, rd);
        wb(0, 1, 8'h00, rd);
        wb(0, 2, 8'h00, rd); chk("stat_unf", rd, 8'h90);
        wb(1, 2, 8'h30, rd);

        wb(1, 0, 8'hC0, rd);
        wb(1, 1, 8'hEE, rd); chk("irq_push", irq_o, 1);
        wb(0, 1, 8'h00, rd); chk("irq_pop", irq_o, 0);
        wb(0, 1, 8'h00, rd);
        repeat (5) @(posedge clk);
        #1; chk("irq_unf_hold", irq_o, 1);
        wb(0, 3, 8'h00, rd); chk("irq_reg", rd, 8'h01);
        wb(1, 2, 8'h10, rd); chk("irq_clear", irq_o, 0);

        for (int i = 0; i < DEPTH + 1; i++) wb(1, 1, 8'($urandom), rd);
        for (int i = 0; i < DEPTH; i++) wb(0, 1, 8'h00, rd);
        wb(1, 2, 8'h30, rd);

        wb(1, 0, 8'h82, rd);
        wb(1, 1, 8'h99, rd);
        cyc = 1; stb = 1; we = 0; adr = 2'd1;
        n = 0;
        while (!ack_o && n < 20) begin @(posedge clk); #1; n++; end
        chk("mid_seen_ack", ack_o, 1);
        rst_n = 0;
        #1;
        chk("mid_rst_ack", ack_o, 0);
        chk("mid_rst_dat", dat_o, 0);
        cyc = 0; stb = 0;
        m_reset();
        #2 rst_n = 1;
        @(posedge clk); #1;
        wb(0, 2, 8'h00, rd); chk("flush", rd, 8'h80);
        wb(1, 0, 8'h80, rd);

        repeat (300) begin
            int r;
            r = $urandom_range(0, 9);
            if (r == 0)
                wb(1, 0, {1'($urandom_range(0, 4) != 0), 1'($urandom), 2'($urandom), 4'($urandom_range(0, 3))}, rd);
            else if (r <= 6) wb(1'($urandom), 1, 8'($urandom), rd);
            else if (r <= 8) wb(1'($urandom), 2, 8'($urandom), rd);
            else wb(0, 2'($urandom), 8'h00, rd);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
